// File: rtl/execute_mul_sched_pkg.sv
// Shared execute-stage types plus the multiplier scheduler pipeline-depth constant.
package execute_mul_sched_pkg;

   localparam int unsigned XLEN               = 32;
   localparam int unsigned ROB_ID_W           = 7;
   localparam int unsigned PHY_ID_W           = 6;
   localparam int unsigned MUL_STAGES_DEFAULT = 2;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'd0,
      MUL_OP_MULH   = 2'd1,
      MUL_OP_MULHSU = 2'd2,
      MUL_OP_MULHU  = 2'd3
   } mul_op_t;

   typedef struct packed {
      mul_op_t mul_op;
   } sub_op_t;

   typedef struct packed {
      logic                enable;
      logic                valid;
      logic [ROB_ID_W-1:0] rob_id;
      logic [XLEN-1:0]     pc;
      logic                rd_enable;
      logic                need_rename;
      logic [PHY_ID_W-1:0] rd_phy;
      logic [XLEN-1:0]     src1_value;
      logic [XLEN-1:0]     src2_value;
      sub_op_t             sub_op;
   } issue_execute_pack_t;

   typedef struct packed {
      logic                enable;
      logic                valid;
      logic [ROB_ID_W-1:0] rob_id;
      logic [XLEN-1:0]     pc;
      logic                rd_enable;
      logic                need_rename;
      logic [PHY_ID_W-1:0] rd_phy;
      logic [XLEN-1:0]     rd_value;
      logic                bru_jump;
      logic [XLEN-1:0]     bru_next_pc;
      logic [XLEN-1:0]     csr_newvalue;
      logic                csr_newvalue_valid;
   } execute_wb_pack_t;

   typedef struct packed {
      logic                enable;
      logic [PHY_ID_W-1:0] phy_id;
      logic [XLEN-1:0]     value;
   } execute_feedback_channel_t;

   typedef struct packed {
      logic enable;
      logic flush;
   } commit_feedback_pack_t;

endpackage

// File: rtl/execute_mul_sched_rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last is served.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt_c
);

   logic last_grant;

   always_comb begin
      gnt_c = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = last_grant ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
         endcase
      end
   end

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        last_grant <= 1'b1;
      else if (|gnt_c) last_grant <= gnt_c[1];
   end

endmodule

// File: rtl/execute_mul_sched.sv
// Multiplier issue scheduler: arbitrates two issue heads, computes the product and
// carries it through MUL_STAGES stallable pipeline stages to writeback.
module execute_mul_sched
   import execute_mul_sched_pkg::*;
#(
   parameter int unsigned MUL_STAGES = MUL_STAGES_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  issue_execute_pack_t       issue_mul0_fifo_data_out,
   input  issue_execute_pack_t       issue_mul1_fifo_data_out,
   input  logic                      issue_mul0_fifo_data_out_valid,
   input  logic                      issue_mul1_fifo_data_out_valid,
   output logic                      issue_mul0_fifo_pop,
   output logic                      issue_mul1_fifo_pop,
   output execute_wb_pack_t          mul_wb_port_data_in,
   output logic                      mul_wb_port_we,
   input  logic                      mul_wb_port_full,
   output execute_feedback_channel_t mul_execute_channel_feedback_pack,
   input  commit_feedback_pack_t     commit_feedback_pack
);

   localparam int unsigned LAST = MUL_STAGES - 1;

   logic                running;
   logic                flush;
   logic                stall;
   logic                grant_en;
   logic [1:0]          gnt;
   issue_execute_pack_t sel;
   logic                a_signed;
   logic                b_signed;
   logic [63:0]         op_a;
   logic [63:0]         op_b;
   logic [63:0]         prod;
   execute_wb_pack_t    wb_in;
   logic                stage_valid [MUL_STAGES];
   execute_wb_pack_t    stage_pack  [MUL_STAGES];

   assign flush    = commit_feedback_pack.enable && commit_feedback_pack.flush;
   assign stall    = stage_valid[LAST] && mul_wb_port_full;
   // No grants until the first edge after reset release.
   assign grant_en = running && !stall && !flush;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (grant_en),
      .req   ({issue_mul1_fifo_data_out_valid, issue_mul0_fifo_data_out_valid}),
      .gnt_c (gnt)
   );

   assign issue_mul0_fifo_pop = gnt[0];
   assign issue_mul1_fifo_pop = gnt[1];

   // Operands are widened per signedness; the low 64 bits of the product are exact.
   always_comb begin
      sel      = gnt[1] ? issue_mul1_fifo_data_out : issue_mul0_fifo_data_out;
      a_signed = (sel.sub_op.mul_op != MUL_OP_MULHU);
      b_signed = (sel.sub_op.mul_op == MUL_OP_MUL) || (sel.sub_op.mul_op == MUL_OP_MULH);
      op_a     = {{32{a_signed & sel.src1_value[31]}}, sel.src1_value};
      op_b     = {{32{b_signed & sel.src2_value[31]}}, sel.src2_value};
      prod     = op_a * op_b;

      wb_in             = '0;
      wb_in.enable      = sel.enable;
      wb_in.valid       = sel.valid;
      wb_in.rob_id      = sel.rob_id;
      wb_in.pc          = sel.pc;
      wb_in.rd_enable   = sel.rd_enable;
      wb_in.need_rename = sel.need_rename;
      wb_in.rd_phy      = sel.rd_phy;
      wb_in.rd_value    = (sel.sub_op.mul_op == MUL_OP_MUL) ? prod[31:0] : prod[63:32];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         running        <= 1'b0;
         stage_valid[0] <= 1'b0;
         stage_pack[0]  <= '0;
      end else begin
         running <= 1'b1;
         if (flush) begin
            stage_valid[0] <= 1'b0;
         end else if (!stall) begin
            stage_valid[0] <= |gnt;
            stage_pack[0]  <= wb_in;
         end
      end
   end

   for (genvar s = 1; s < MUL_STAGES; s++) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            stage_valid[s] <= 1'b0;
            stage_pack[s]  <= '0;
         end else if (flush) begin
            stage_valid[s] <= 1'b0;
         end else if (!stall) begin
            stage_valid[s] <= stage_valid[s-1];
            stage_pack[s]  <= stage_pack[s-1];
         end
      end
   end

   assign mul_wb_port_data_in = stage_pack[LAST];
   assign mul_wb_port_we      = stage_valid[LAST] && !mul_wb_port_full && !flush;

   always_comb begin
      mul_execute_channel_feedback_pack        = '0;
      mul_execute_channel_feedback_pack.enable = mul_wb_port_we
                                                 && stage_pack[LAST].enable
                                                 && stage_pack[LAST].valid
                                                 && stage_pack[LAST].rd_enable
                                                 && stage_pack[LAST].need_rename;
      mul_execute_channel_feedback_pack.phy_id = stage_pack[LAST].rd_phy;
      mul_execute_channel_feedback_pack.value  = stage_pack[LAST].rd_value;
   end

endmodule

// File: tb/tb_execute_mul_sched.sv
// Directed + random bench for execute_mul_sched with a result scoreboard.
module tb_execute_mul_sched;
   import execute_mul_sched_pkg::*;

   localparam int unsigned N = 2;

   logic                      clk;
   logic                      rst;
   issue_execute_pack_t       p0, p1;
   logic                      v0, v1;
   logic                      pop0, pop1;
   execute_wb_pack_t          wb;
   logic                      we;
   logic                      full;
   execute_feedback_channel_t fb;
   commit_feedback_pack_t     cf;

   execute_mul_sched #(.MUL_STAGES(N)) dut (
      .clk                               (clk),
      .rst                               (rst),
      .issue_mul0_fifo_data_out          (p0),
      .issue_mul1_fifo_data_out          (p1),
      .issue_mul0_fifo_data_out_valid    (v0),
      .issue_mul1_fifo_data_out_valid    (v1),
      .issue_mul0_fifo_pop               (pop0),
      .issue_mul1_fifo_pop               (pop1),
      .mul_wb_port_data_in               (wb),
      .mul_wb_port_we                    (we),
      .mul_wb_port_full                  (full),
      .mul_execute_channel_feedback_pack (fb),
      .commit_feedback_pack              (cf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0]  rob;
      logic [31:0] pc;
      logic [31:0] val;
      logic        valid;
      logic        fb_en;
      logic [5:0]  phy;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   logic mv [N];
   logic m_last;
   logic m_run;
   logic m_g0, m_g1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] ref_mul(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (op)
         MUL_OP_MUL:    begin t = 64'(sa * sb);          return t[31:0];  end
         MUL_OP_MULH:   begin t = 64'(sa * sb);          return t[63:32]; end
         MUL_OP_MULHSU: begin t = 64'(sa * longint'(ub)); return t[63:32]; end
         default:       begin t = ua * ub;               return t[63:32]; end
      endcase
   endfunction

   function automatic issue_execute_pack_t mk(input logic [6:0] rob, input mul_op_t op,
                                              input logic [31:0] a, input logic [31:0] b);
      issue_execute_pack_t p;
      p               = '0;
      p.enable        = 1'b1;
      p.valid         = 1'b1;
      p.rob_id        = rob;
      p.pc            = 32'h1000 + 32'({rob, 2'b00});
      p.rd_enable     = 1'b1;
      p.need_rename   = 1'b1;
      p.rd_phy        = rob[5:0] ^ 6'h15;
      p.src1_value    = a;
      p.src2_value    = b;
      p.sub_op.mul_op = op;
      return p;
   endfunction

   function automatic issue_execute_pack_t rnd(input logic [6:0] rob);
      issue_execute_pack_t p;
      p             = mk(rob, mul_op_t'(2'($urandom_range(0, 3))), $urandom, $urandom);
      p.valid       = ($urandom_range(0, 7) != 0);
      p.rd_enable   = 1'($urandom_range(0, 1));
      p.need_rename = 1'($urandom_range(0, 1));
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) mv[i] = 1'b0;
      m_last = 1'b1;
      m_run  = 1'b0;
      q.delete();
   endtask

   // One clock: check combinational outputs against the model, then advance the model.
   task automatic tick();
      logic fl, st, ok, g0, g1, ew;
      exp_t e;
      issue_execute_pack_t s;
      #1;
      fl = cf.enable && cf.flush;
      st = mv[N-1] && full;
      ok = rst && m_run && !st && !fl;
      g0 = 1'b0;
      g1 = 1'b0;
      if (ok) begin
         if (v0 && v1) begin
            if (m_last) g0 = 1'b1;
            else        g1 = 1'b1;
         end else begin
            g0 = v0;
            g1 = v1;
         end
      end
      chk("pop0", 64'(pop0), 64'(g0));
      chk("pop1", 64'(pop1), 64'(g1));
      ew = rst && mv[N-1] && !full && !fl;
      chk("we", 64'(we), 64'(ew));
      if (ew) begin
         chk("sb_nonempty", 64'(q.size() != 0), 64'(1));
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("wb_rob", 64'(wb.rob_id), 64'(e.rob));
            chk("wb_pc", 64'(wb.pc), 64'(e.pc));
            chk("wb_valid", 64'(wb.valid), 64'(e.valid));
            if (e.valid) chk("wb_rd_value", 64'(wb.rd_value), 64'(e.val));
            chk("wb_side_zero", 64'({wb.bru_jump, wb.csr_newvalue_valid, (wb.bru_next_pc != 0),
                                     (wb.csr_newvalue != 0)}), 64'(0));
            chk("fb_en", 64'(fb.enable), 64'(e.fb_en));
            if (e.fb_en) begin
               chk("fb_phy", 64'(fb.phy_id), 64'(e.phy));
               chk("fb_value", 64'(fb.value), 64'(e.val));
            end
         end
      end else begin
         chk("fb_en_idle", 64'(fb.enable), 64'(0));
      end
      if (g0 || g1) begin
         s       = g1 ? p1 : p0;
         e.rob   = s.rob_id;
         e.pc    = s.pc;
         e.val   = ref_mul(s.sub_op.mul_op, s.src1_value, s.src2_value);
         e.valid = s.valid;
         e.fb_en = s.enable && s.valid && s.rd_enable && s.need_rename;
         e.phy   = s.rd_phy;
         q.push_back(e);
         m_last = g1;
      end
      m_g0 = g0;
      m_g1 = g1;
      @(posedge clk);
      if (rst) begin
         m_run = 1'b1;
         if (fl) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
            q.delete();
         end else if (!st) begin
            for (int i = N - 1; i > 0; i--) mv[i] = mv[i-1];
            mv[0] = g0 || g1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [6:0] rob;
      rst  = 1'b0;
      v0   = 1'b0;
      v1   = 1'b0;
      full = 1'b0;
      cf   = '0;
      p0   = '0;
      p1   = '0;
      model_reset();
      @(negedge clk);
      idle(2);
      rst = 1'b1;
      tick();

      // Requester 0 alone: -1 * 2 low word.
      p0 = mk(7'd1, MUL_OP_MUL, 32'hFFFF_FFFF, 32'd2);
      v0 = 1'b1; tick(); v0 = 1'b0; idle(3);

      // Requester 1 alone: mulh -1 * -1 (also leaves last_grant on 1).
      p1 = mk(7'd4, MUL_OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      v1 = 1'b1; tick(); v1 = 1'b0; idle(3);

      // Both valid for 4 cycles: alternating grants 0,1,0,1.
      p0 = mk(7'd2, MUL_OP_MULHU, 32'h8000_0000, 32'd4);
      p1 = mk(7'd3, MUL_OP_MULHU, 32'h8000_0000, 32'd4);
      v0 = 1'b1; v1 = 1'b1; idle(4); v0 = 1'b0; v1 = 1'b0; idle(3);

      // mulhsu with all-ones operands.
      p0 = mk(7'd6, MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      v0 = 1'b1; tick(); v0 = 1'b0; idle(3);

      // Backpressure with the pipeline full for 3 cycles, then drain.
      v0 = 1'b1;
      p0 = mk(7'd10, MUL_OP_MUL, 32'd3, 32'd5);       tick();
      p0 = mk(7'd11, MUL_OP_MUL, 32'd7, 32'hFFFF_FFF7); tick();
      p0 = mk(7'd12, MUL_OP_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      full = 1'b1; idle(3);
      full = 1'b0; tick();
      v0 = 1'b0; idle(3);

      // Flush with two ops in flight; next pop accepted right after.
      v0 = 1'b1;
      p0 = mk(7'd20, MUL_OP_MUL, 32'd11, 32'd13); tick();
      p0 = mk(7'd21, MUL_OP_MUL, 32'd17, 32'd19); tick();
      p0 = mk(7'd22, MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cf = '{enable: 1'b1, flush: 1'b1}; tick();
      cf = '0; tick();
      v0 = 1'b0; idle(3);

      // Reset mid-stream: in-flight ops dropped, first tie goes to requester 0.
      v0 = 1'b1;
      p0 = mk(7'd30, MUL_OP_MUL, 32'd2, 32'd3); tick();
      p0 = mk(7'd31, MUL_OP_MUL, 32'd4, 32'd5); tick();
      rst = 1'b0;
      model_reset();
      p0 = mk(7'd40, MUL_OP_MUL, 32'hDEAD_BEEF, 32'd9);
      p1 = mk(7'd41, MUL_OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF);
      v1 = 1'b1; tick();
      rst = 1'b1; tick();
      tick();
      chk("tie_after_reset_grant0", 64'(m_g0), 64'(1));
      p0 = mk(7'd42, MUL_OP_MUL, 32'd6, 32'd7); tick();
      v0 = 1'b0; v1 = 1'b0; idle(3);

      // Random traffic with occasional backpressure.
      rob = 7'd50;
      p0 = rnd(rob); rob++;
      p1 = rnd(rob); rob++;
      for (int i = 0; i < 40; i++) begin
         v0   = 1'($urandom_range(0, 1));
         v1   = 1'($urandom_range(0, 1));
         full = ($urandom_range(0, 4) == 0);
         tick();
         if (m_g0) begin p0 = rnd(rob); rob++; end
         if (m_g1) begin p1 = rnd(rob); rob++; end
      end
      v0 = 1'b0; v1 = 1'b0; full = 1'b0;
      idle(4);
      chk("sb_drained", 64'(q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
